// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network encoders/decoders.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } enc_state_t;

  // Bits needed for a counter reaching max(slots-1, guard_cycles-1) without wrapping.
  function automatic int ctr_width(input int slots, input int guard_cycles);
    int top;
    top = (slots - 1 > guard_cycles - 1) ? slots - 1 : guard_cycles - 1;
    if (top < 1) return 1;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/spike_encoder.sv
// Time-to-first-spike encoder: one value becomes one spike inside a window of
// SLOTS cycles, followed by GUARD_CYCLES silent cycles.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int INT_WIDTH    = 4,
  parameter int SLOT_SHIFT   = 0,
  parameter int GUARD_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [INT_WIDTH-1:0] in_value,
  output logic                 in_ready,
  output logic                 spike,
  output logic                 window_start,
  output logic                 busy
);

  localparam int SW    = INT_WIDTH - SLOT_SHIFT;
  localparam int SLOTS = 1 << SW;
  localparam int CW    = ctr_width(SLOTS, GUARD_CYCLES);

  localparam logic [INT_WIDTH-1:0] INT_MAX    = '1;
  localparam logic [CW-1:0]        RUN_LAST   = CW'(SLOTS - 1);
  localparam logic [CW-1:0]        GUARD_LAST = CW'(GUARD_CYCLES - 1);

  enc_state_t         state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [SW-1:0]      slot, slot_nxt;
  logic               zero, zero_nxt;
  logic               transfer;
  logic [INT_WIDTH-1:0] diff;

  assign diff     = INT_MAX - in_value;
  assign transfer = (state == IDLE) && in_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_nxt  = slot;
    zero_nxt  = zero;
    case (state)
      IDLE: begin
        if (in_valid) begin
          slot_nxt  = SW'(diff >> SLOT_SHIFT);
          zero_nxt  = (in_value == '0);
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == RUN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (GUARD_CYCLES == 0) ? IDLE : GUARD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      slot         <= '0;
      zero         <= 1'b0;
      spike        <= 1'b0;
      window_start <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      slot         <= slot_nxt;
      zero         <= zero_nxt;
      spike        <= (state_nxt == RUN) && (cnt_nxt == CW'(slot_nxt)) && !zero_nxt;
      window_start <= transfer;
      busy         <= (state_nxt != IDLE);
      in_ready     <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench: three encoder configurations driven with directed and random stimulus.
module tb_spike_encoder;

  localparam int EV_WS    = 0;
  localparam int EV_SPIKE = 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic [2:0] vld;
  logic [2:0] rst_v;
  logic [3:0] val [3];
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Config 0: shift 0 / guard 5, config 1: shift 2 / guard 5, config 2: shift 0 / guard 0.
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int SH = (g == 1) ? 2 : 0;
    localparam int GC = (g == 2) ? 0 : 5;
    localparam int NS = 16 >> SH;

    logic rdy, spk, ws, bsy;
    ev_t  q[$];
    int   next_free = 0;

    spike_encoder #(
      .INT_WIDTH   (4),
      .SLOT_SHIFT  (SH),
      .GUARD_CYCLES(GC)
    ) dut (
      .clk         (clk),
      .rst         (rst_v[g]),
      .in_valid    (vld[g]),
      .in_value    (val[g]),
      .in_ready    (rdy),
      .spike       (spk),
      .window_start(ws),
      .busy        (bsy)
    );

    // Reference model: a window accepted at edge E starts in cycle E+1 and frees the encoder at cycle E+1+NS+GC.
    always @(posedge clk) begin
      if (rst_v[g]) begin
        q.delete();
        if (cyc < next_free) next_free = cyc + 1;
      end else if (vld[g] && cyc >= next_free) begin
        int s;
        s = (15 - int'(val[g])) >> SH;
        q.push_back('{EV_WS, cyc + 1});
        if (val[g] != 4'd0) q.push_back('{EV_SPIKE, cyc + 1 + s});
        next_free = cyc + 1 + NS + GC;
      end
    end

    task automatic check_ev(input int kind, input string nm);
      total++;
      if (q.size() == 0 || q[0].kind != kind || q[0].cyc != cyc) begin
        bad++;
        $display("[TB] FAIL %s cfg%0d: seen at cyc=%0d, expected cyc=%0d", nm, g, cyc,
                 (q.size() > 0) ? q[0].cyc : -1);
        if (q.size() > 0 && q[0].kind == kind) void'(q.pop_front());
      end else begin
        void'(q.pop_front());
      end
    endtask

    always @(negedge clk) begin
      if (mon_en) begin
        total++;
        if (rdy !== (cyc >= next_free)) begin
          bad++;
          $display("[TB] FAIL in_ready cfg%0d cyc=%0d: got %b, want %b", g, cyc, rdy, (cyc >= next_free));
        end
        total++;
        if (bsy !== (cyc < next_free)) begin
          bad++;
          $display("[TB] FAIL busy cfg%0d cyc=%0d: got %b, want %b", g, cyc, bsy, (cyc < next_free));
        end
        if (ws !== 1'b0) check_ev(EV_WS, "window_start");
        if (spk !== 1'b0) check_ev(EV_SPIKE, "spike");
        while (q.size() > 0 && q[0].cyc <= cyc) begin
          total++;
          bad++;
          $display("[TB] FAIL missing_%s cfg%0d: no pulse at expected cyc=%0d",
                   (q[0].kind == EV_WS) ? "window_start" : "spike", g, q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int k, input logic [3:0] v);
    @(negedge clk);
    vld[k] = 1'b1;
    val[k] = v;
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vld   = '0;
    rst_v = '1;
    for (int k = 0; k < 3; k++) val[k] = '0;
    idleCycles(3);
    rst_v = '0;
    @(negedge clk);
    mon_en = 1'b1;
    idleCycles(2);

    applyStimulus(0, 4'd15);
    idleCycles(24);
    applyStimulus(0, 4'd1);
    idleCycles(24);
    applyStimulus(0, 4'd0);
    idleCycles(24);

    // valid held high with changing data: only the value present at a free edge is taken
    @(negedge clk);
    vld[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      val[0] = 4'(i * 7 + 3);
      @(negedge clk);
    end
    vld[0] = 1'b0;
    idleCycles(24);

    // reset in the sixth cycle of a window whose spike would land in cycle 11
    applyStimulus(0, 4'd5);
    idleCycles(5);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    idleCycles(20);

    // reset and transfer on the same edge
    vld[0]   = 1'b1;
    val[0]   = 4'd15;
    rst_v[0] = 1'b1;
    @(negedge clk);
    vld[0]   = 1'b0;
    rst_v[0] = 1'b0;
    idleCycles(4);

    applyStimulus(1, 4'd8);
    idleCycles(12);
    applyStimulus(1, 4'd3);
    idleCycles(12);

    @(negedge clk);
    vld[2] = 1'b1;
    val[2] = 4'd15;
    idleCycles(40);
    vld[2] = 1'b0;
    idleCycles(20);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vld[k]   = ($urandom_range(0, 3) == 0);
        val[k]   = 4'($urandom_range(0, 15));
        rst_v[k] = ($urandom_range(0, 149) == 0);
      end
    end
    @(negedge clk);
    vld   = '0;
    rst_v = '0;
    idleCycles(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
